// File: rtl/rv_exe_muldiv.sv
// Iterative RV32/64 M-extension multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
module rv_exe_muldiv #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_Q102H,
  output logic            req_ready_Q102H,
  input  logic [2:0]      req_op_Q102H,
  input  logic [XLEN-1:0] req_src1_Q102H,
  input  logic [XLEN-1:0] req_src2_Q102H,
  input  logic [4:0]      req_rd_Q102H,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            busy
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned AW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic [AW-1:0]   r_acc;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_res;

  logic            w_accept, w_special, w_div_zero, w_div_ovf;
  logic            w_s1_neg, w_s2_neg, w_neg_req;
  logic [XLEN-1:0] w_abs1, w_abs2, w_spec_quo, w_spec_rem;
  logic [AW-1:0]   w_step, w_mneg;
  logic [XLEN:0]   w_sum, w_trial;
  logic [XLEN-1:0] w_q, w_r, w_fix_res;

  assign req_ready_Q102H = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign rsp_valid       = (r_state == S_DONE);
  assign rsp_data        = r_res;
  assign rsp_rd          = r_rd;

  // Request decode: operand signedness, magnitudes and divide special cases
  always_comb begin
    w_accept   = req_valid_Q102H & (r_state == S_IDLE) & ~flush;
    w_s1_neg   = req_src1_Q102H[XLEN-1] &
                 (req_op_Q102H[2] ? ~req_op_Q102H[0] : (req_op_Q102H[1:0] != 2'd3));
    w_s2_neg   = req_src2_Q102H[XLEN-1] &
                 (req_op_Q102H[2] ? ~req_op_Q102H[0] : ~req_op_Q102H[1]);
    w_abs1     = w_s1_neg ? (~req_src1_Q102H + XLEN'(1)) : req_src1_Q102H;
    w_abs2     = w_s2_neg ? (~req_src2_Q102H + XLEN'(1)) : req_src2_Q102H;
    w_neg_req  = (req_op_Q102H[2] & req_op_Q102H[1]) ? w_s1_neg : (w_s1_neg ^ w_s2_neg);
    w_div_zero = req_op_Q102H[2] & (req_src2_Q102H == '0);
    w_div_ovf  = req_op_Q102H[2] & ~req_op_Q102H[0] &
                 (req_src1_Q102H == MIN_INT) & (req_src2_Q102H == '1);
    w_special  = w_div_zero | w_div_ovf;
    w_spec_quo = w_div_zero ? '1 : req_src1_Q102H;
    w_spec_rem = w_div_zero ? req_src1_Q102H : '0;
  end

  // One CALC cycle: BITS_PER_CYCLE chained shift-add or restoring steps
  always_comb begin
    w_step  = r_acc;
    w_sum   = '0;
    w_trial = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (r_op[2]) begin
        w_trial = {w_step[AW-1:XLEN], w_step[XLEN-1]};
        if (w_trial >= {1'b0, r_b}) begin
          w_trial = w_trial - {1'b0, r_b};
          w_step  = {w_trial[XLEN-1:0], w_step[XLEN-2:0], 1'b1};
        end else begin
          w_step  = {w_trial[XLEN-1:0], w_step[XLEN-2:0], 1'b0};
        end
      end else begin
        w_sum  = {1'b0, w_step[AW-1:XLEN]} + (w_step[0] ? {1'b0, r_b} : '0);
        w_step = {w_sum, w_step[XLEN-1:1]};
      end
    end
  end

  // Sign fix-up and result select
  always_comb begin
    w_mneg = r_neg ? (~r_acc + AW'(1)) : r_acc;
    w_q    = r_neg ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    w_r    = r_neg ? (~r_acc[AW-1:XLEN] + XLEN'(1)) : r_acc[AW-1:XLEN];
    case (r_op)
      3'd0:          w_fix_res = w_mneg[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          w_fix_res = w_mneg[AW-1:XLEN];
      3'd4, 3'd5:    w_fix_res = w_q;
      default:       w_fix_res = w_r;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Special divides preload quotient/remainder and pass through FIX unnegated,
  // so their response lands one edge after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_acc <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op_Q102H;
        r_rd  <= req_rd_Q102H;
        r_cnt <= CW'(N);
        r_b   <= w_abs2;
        r_neg <= w_special ? 1'b0 : w_neg_req;
        r_acc <= w_special ? {w_spec_rem, w_spec_quo} : {XLEN'(0), w_abs1};
      end
      if (r_state == S_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == S_FIX) r_res <= w_fix_res;
    end
  end

endmodule

// File: tb/tb_rv_exe_muldiv.sv
// Bench for rv_exe_muldiv: BPC=1 and BPC=4 instances driven in lockstep,
// vector table plus random ops against a 64-bit reference model.
module tb_rv_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, flush, rsp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic [4:0]  req_rd;

  logic        rdy1, vld1, busy1, rdy4, vld4, busy4;
  logic [31:0] data1, data4;
  logic [4:0]  rd1, rd4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        spec;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          lat;
  } sb_t;

  sb_t  q1[$];
  sb_t  q4[$];
  vec_t vt[14];

  always #5 clk = ~clk;

  rv_exe_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid_Q102H(req_valid), .req_ready_Q102H(rdy1), .req_op_Q102H(req_op),
    .req_src1_Q102H(req_src1), .req_src2_Q102H(req_src2), .req_rd_Q102H(req_rd),
    .flush(flush), .rsp_valid(vld1), .rsp_ready(rsp_ready),
    .rsp_data(data1), .rsp_rd(rd1), .busy(busy1));

  rv_exe_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst),
    .req_valid_Q102H(req_valid), .req_ready_Q102H(rdy4), .req_op_Q102H(req_op),
    .req_src1_Q102H(req_src1), .req_src2_Q102H(req_src2), .req_rd_Q102H(req_rd),
    .flush(flush), .rsp_valid(vld4), .rsp_ready(rsp_ready),
    .rsp_data(data4), .rsp_rd(rd4), .busy(busy4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (op)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; end
      3'd6: begin if (b == 0) return a; p = sa % sb; end
      default: begin if (b == 0) return a; p = ua % ub; end
    endcase
    return p[31:0];
  endfunction

  // Drive one op into both units, scoreboard the expected response, hold it
  // in DONE for `stall` cycles, then hand it off.
  task automatic run_vec(input vec_t v, input int stall);
    sb_t e;
    logic got1, got4, busy_bad, stall_bad;
    logic [31:0] d1s;
    logic [4:0]  r1s;
    q1.push_back('{v.exp, v.rd, v.spec ? 1 : 33});
    q4.push_back('{v.exp, v.rd, v.spec ? 1 : 9});
    chk("req_ready_before", {30'd0, rdy1, rdy4}, 32'd3);
    req_valid = 1'b1; req_op = v.op; req_src1 = v.a; req_src2 = v.b; req_rd = v.rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got1 = 1'b0; got4 = 1'b0; busy_bad = 1'b0;
    for (int c = 1; c <= 100 && !(got1 && got4); c++) begin
      if (!got1 && busy1 !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1;
      if (!got1 && vld1) begin
        got1 = 1'b1;
        e = q1.pop_front();
        chk($sformatf("data1 op%0d", v.op), data1, e.data);
        chk($sformatf("rd1 op%0d", v.op), 32'(rd1), 32'(e.rd));
        chk($sformatf("lat1 op%0d", v.op), 32'(c), 32'(e.lat));
      end
      if (!got4 && vld4) begin
        got4 = 1'b1;
        e = q4.pop_front();
        chk($sformatf("data4 op%0d", v.op), data4, e.data);
        chk($sformatf("rd4 op%0d", v.op), 32'(rd4), 32'(e.rd));
        chk($sformatf("lat4 op%0d", v.op), 32'(c), 32'(e.lat));
      end
    end
    chk("rsp_timeout", {30'd0, got1, got4}, 32'd3);
    chk("busy1_during_op", {31'd0, busy_bad}, 32'd0);
    if (!got1) void'(q1.pop_front());
    if (!got4) void'(q4.pop_front());
    if (stall > 0) begin
      d1s = data1; r1s = rd1; stall_bad = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (data1 !== d1s || rd1 !== r1s || rdy1 !== 1'b0 || vld1 !== 1'b1) stall_bad = 1'b1;
      end
      chk("stall_stable", {31'd0, stall_bad}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("req_ready_after", {30'd0, rdy1, rdy4}, 32'd3);
    chk("valid_after", {30'd0, vld1, vld4}, 32'd0);
  endtask

  task automatic no_rsp(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (vld1 || vld4) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    vec_t v;
    vt[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0};
    vt[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 1'b0};
    vt[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 1'b0};
    vt[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 1'b0};
    vt[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 1'b0};
    vt[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 1'b0};
    vt[6]  = '{3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       1'b0};
    vt[7]  = '{3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        1'b0};
    vt[8]  = '{3'd4, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1'b1};
    vt[9]  = '{3'd6, 32'd5,        32'd0,        5'd14, 32'd5,        1'b1};
    vt[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1};
    vt[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1'b1};
    vt[12] = '{3'd5, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1'b1};
    vt[13] = '{3'd7, 32'h12345678, 32'd0,        5'd31, 32'h12345678, 1'b1};

    rst = 1'b0; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_src1 = '0; req_src2 = '0; req_rd = '0;
    #22;
    chk("rst_valid", {30'd0, vld1, vld4}, 32'd0);
    chk("rst_busy", {30'd0, busy1, busy4}, 32'd0);
    chk("rst_data", data1 | data4, 32'd0);
    chk("rst_rd", 32'(rd1 | rd4), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {30'd0, rdy1, rdy4}, 32'd3);

    run_vec(vt[0], 5);
    for (int i = 1; i < 14; i++) run_vec(vt[i], 0);

    for (int i = 0; i < 16; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.a  = $urandom;
      v.b  = $urandom;
      if ($urandom_range(0, 3) == 0) v.b = '0;
      if ($urandom_range(0, 7) == 0) begin v.a = 32'h80000000; v.b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) v.b = v.b >> $urandom_range(16, 31);
      v.rd   = 5'($urandom_range(0, 31));
      v.exp  = ref_model(v.op, v.a, v.b);
      v.spec = v.op[2] && (v.b == 0 || (!v.op[0] && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF));
      run_vec(v, 0);
    end

    // Flush at CALC cycle 10: u1 is still iterating, u4 is waiting in DONE
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 32'd3; req_src2 = 32'd9; req_rd = 5'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {30'd0, busy1, busy4}, 32'd0);
    chk("flush_ready", {30'd0, rdy1, rdy4}, 32'd3);
    chk("flush_valid", {30'd0, vld1, vld4}, 32'd0);
    no_rsp("flush_no_rsp", 40);

    // Flush wins over a simultaneous request
    req_valid = 1'b1; flush = 1'b1; req_op = 3'd5; req_src1 = 32'd9; req_src2 = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_busy", {30'd0, busy1, busy4}, 32'd0);
    no_rsp("flush_accept_no_rsp", 40);

    // Async reset mid-CALC
    req_valid = 1'b1; req_op = 3'd1; req_src1 = 32'd77; req_src2 = 32'd99; req_rd = 5'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {30'd0, vld1, vld4}, 32'd0);
    chk("arst_busy", {30'd0, busy1, busy4}, 32'd0);
    chk("arst_data", data1 | data4, 32'd0);
    chk("arst_rd", 32'(rd1 | rd4), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    no_rsp("arst_no_rsp", 40);

    run_vec(vt[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
